pair_add_sequencer: RTL and testbench
=====================================

Name: pair_add_sequencer

Overview:
- Upstream/downstream wrapper stage for the team's fixed-point adder.
- Accepts a stream of signed Q8.8 samples and groups them into consecutive (A, B) pairs.
- Drives the adder's A/B/enable inputs, captures its Q9.7 sum after a fixed latency, and buffers results in an output FIFO with valid/ready.
- Decouples the sample source from the adder's enable-pulse protocol.

Parameters:
- ADD_LATENCY, 2: clock edges from the edge sampling add_en=1 to the edge at which add_sum is valid; legal range 1..15.
- FIFO_DEPTH, 4: output FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- s_data  in  16  signed Q8.8 input sample
- s_valid  in  1  s_data valid
- s_ready  out  1  block accepts s_data this cycle
- add_a  out  16  signed Q8.8 operand A to adder
- add_b  out  16  signed Q8.8 operand B to adder
- add_en  out  1  adder enable, one-cycle pulse
- add_sum  in  16  signed Q9.7 sum from adder
- m_data  out  16  signed Q9.7 result
- m_valid  out  1  m_data valid
- m_ready  in  1  consumer accepts m_data
- err_mismatch  out  1  sticky sum-check error (see Optional Feature)

Behaviour:
- Single clock domain. Reset is asynchronous, active-high, and applies to every register.
- Reset values:
  - s_ready=0 while reset is asserted, then 1 in the first cycle after release.
  - add_a=0, add_b=0, add_en=0.
  - m_valid=0, m_data=0.
  - err_mismatch=0.
  - FIFO empty; pending operand discarded.
- FSM states and transitions:
  - GET_A: s_ready=1. On s_valid&s_ready, register s_data into add_a and go to GET_B.
  - GET_B: s_ready=1. On handshake, register s_data into add_b and go to ISSUE.
  - ISSUE: s_ready=0.
    - If FIFO not full: add_en=1 for exactly this cycle, load latency counter with ADD_LATENCY, go to WAIT.
    - If FIFO full: stay in ISSUE with add_en=0.
  - WAIT: s_ready=0, add_en=0. Decrement the counter each edge. On the edge where the counter reaches 0:
    - sample add_sum into the FIFO (always room, because only this block writes and ISSUE checked not-full);
    - go to GET_A.
- add_a and add_b hold their values from capture until the next capture; they are stable through ISSUE and WAIT.
- Latency:
  - B handshake at edge E0 → add_en high during cycle E0..E1.
  - add_sum written to the FIFO at edge E1+ADD_LATENCY.
  - m_valid high in the following cycle if the FIFO was empty.
  - Pair period with no backpressure: ADD_LATENCY+3 cycles.
- Adder contract: add_sum = (sext17(A)+sext17(B)) >>> 1, i.e. the 17-bit sum arithmetic-shifted right by 1 and interpreted as Q9.7. Never overflows.
- FIFO:
  - first-fall-through; m_data is the head entry.
  - pop on m_valid&m_ready.
- Simultaneous FIFO write and pop:
  - When not empty, both occur and the count is unchanged.
  - When empty, the write is seen at the head next cycle; a same-cycle pop is impossible because m_valid=0.
- Odd sample count: the A operand stays pending in GET_B indefinitely. No timeout.
- Reset mid-operation, including WAIT: the in-flight sum is discarded. A late add_sum is ignored because the FSM is in GET_A.
- m_data stays stable while m_valid=1 and m_ready=0.

Optional Feature:
- Macro: PAIR_SUM_CHECK_EN
- With the macro defined:
  - At capture, compute the expected value (17-bit A+B)>>>1 internally and compare it with add_sum.
  - On mismatch, set err_mismatch=1, sticky until reset. The sum is still enqueued.
- Without the macro:
  - err_mismatch is tied to 0.
  - No comparator logic is generated.
  - Port list is unchanged.

Decomposition:
- Package pair_add_pkg:
  - Q88_W=16, Q97_W=16;
  - FSM state typedef {GET_A, GET_B, ISSUE, WAIT};
  - function computing the expected Q9.7 sum.
- One sub-module: sync_fifo, holding 16-bit data and FIFO_DEPTH entries, with full/empty/count outputs.
- The FSM and latency counter stay in the top module.

Test Plan:
- Basic pair: s_data 0x0100 (1.0) then 0x0200 (2.0), adder model returns 0x0180 → m_data=0x0180 (3.0). m_valid rises exactly ADD_LATENCY+2 cycles after the B handshake edge, and add_en is high for exactly one cycle.
- Extremes:
  - 0x7FFF+0x7FFF → 0x7FFF
  - 0x8000+0x8000 → 0x8000
  - 0xFFFF+0x0000 → 0xFFFF (arithmetic shift, −1 LSB)
  - err_mismatch stays 0 throughout.
- Backpressure with m_ready=0 and 12 samples (6 pairs) presented:
  - FIFO fills with 4 results.
  - FSM stalls in ISSUE with add_en=0 and s_ready=0.
  - Raise m_ready: all 6 results drain in input order; no pair is lost or duplicated.
- Reset mid-WAIT:
  - Assert reset one cycle after add_en.
  - After release: m_valid=0, FIFO empty, s_ready=1.
  - Next pair 0x0080+0x0080 → 0x0080 as the only output.
- With PAIR_SUM_CHECK_EN, adder model corrupts one sum (returns 0x0000 for 0x0100+0x0100):
  - err_mismatch=1 from the cycle after capture and stays set.
  - The corrupted value is still output.
  - err_mismatch clears only on reset.

Source files
------------

// File: rtl/pair_add_pkg.sv
// Shared widths, FSM state encoding and the reference Q9.7 pair-sum for the pair-add sequencer.
package pair_add_pkg;

    localparam int Q88_W = 16;
    localparam int Q97_W = 16;
    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        GET_A,
        GET_B,
        ISSUE,
        WAIT
    } state_t;

    // 17-bit signed sum halved, so the Q9.7 result can never overflow.
    function automatic logic [Q97_W-1:0] expected_sum(
        input logic signed [Q88_W-1:0] a,
        input logic signed [Q88_W-1:0] b
    );
        logic signed [Q88_W:0] sum;
        sum = (Q88_W+1)'(a) + (Q88_W+1)'(b);
        return Q97_W'(sum >>> 1);
    endfunction

endpackage

// File: rtl/pair_add_sequencer_sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head entry is always visible on rd_data_o.
module sync_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rd_en_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_wr;
    logic              do_rd;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign do_wr     = wr_en_i && !full_o;
    assign do_rd     = rd_en_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pair_add_sequencer.sv
// Groups Q8.8 samples into (A,B) pairs, pulses the external adder and queues its Q9.7 sums.
// Optional macro PAIR_SUM_CHECK_EN adds a sticky comparator against the expected sum.
module pair_add_sequencer
    import pair_add_pkg::*;
#(
    parameter int ADD_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_en,
    input  logic [15:0] add_sum,
    output logic [15:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        err_mismatch
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t                  state_q, state_d;
    logic signed [Q88_W-1:0] a_q, a_d;
    logic signed [Q88_W-1:0] b_q, b_d;
    logic [LAT_W-1:0]        lat_q, lat_d;
    logic                    ready_st;
    logic                    capture;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= GET_A;
            a_q     <= '0;
            b_q     <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        lat_d    = lat_q;
        ready_st = 1'b0;
        add_en   = 1'b0;
        capture  = 1'b0;
        case (state_q)
            GET_A: begin
                ready_st = 1'b1;
                if (s_valid) begin
                    a_d     = s_data;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                ready_st = 1'b1;
                if (s_valid) begin
                    b_d     = s_data;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Only issue when the result is guaranteed a FIFO slot on return.
                if (fifo_count < CNT_W'(FIFO_DEPTH)) begin
                    add_en  = 1'b1;
                    lat_d   = LAT_W'(ADD_LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    capture = 1'b1;
                    state_d = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase
    end

    // Ready is masked while reset is held so nothing is accepted before release.
    assign s_ready = ready_st & ~reset;
    assign add_a   = a_q;
    assign add_b   = b_q;
    assign m_valid = ~fifo_empty;

    sync_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (Q97_W)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (reset),
        .wr_en_i   (capture & ~fifo_full),
        .wr_data_i (add_sum),
        .rd_en_i   (m_ready),
        .rd_data_o (m_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

`ifdef PAIR_SUM_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (capture && (add_sum != expected_sum(a_q, b_q))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_mismatch = err_q;
`else
    assign err_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_pair_add_sequencer.sv
// Directed bench for pair_add_sequencer with a behavioural adder of ADD_LATENCY stages.
module tb_pair_add_sequencer;

    localparam int L = 2;

    logic        clk;
    logic        reset;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_en;
    logic [15:0] add_sum;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        err_mismatch;

    int vec  = 0;
    int errs = 0;
    logic corrupt_en;

    pair_add_sequencer #(
        .ADD_LATENCY (L),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_en       (add_en),
        .add_sum      (add_sum),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .err_mismatch (err_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder model: operands sampled with add_en, result presented L edges later.
    logic [16:0] model_wide;
    logic [15:0] model_sum;
    logic [15:0] pipe [L];
    always_comb begin
        model_wide = {add_a[15], add_a} + {add_b[15], add_b};
        model_sum  = model_wide[16:1];
        if (corrupt_en && add_a == 16'h0100 && add_b == 16'h0100) model_sum = 16'h0000;
    end
    always @(posedge clk) begin
        if (add_en) pipe[0] <= model_sum;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign add_sum = pipe[L-1];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns #1 after the handshake edge.
    task automatic send(input logic [15:0] d);
        int n;
        n = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && n < 200) begin
            tick;
            n++;
        end
        check("send_ready", {31'd0, s_ready}, 32'd1);
        tick;
        s_valid = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [15:0] exp);
        int n;
        n = 0;
        while (!m_valid && n < 100) begin
            tick;
            n++;
        end
        check({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
        check({tag, "_data"}, {16'd0, m_data}, {16'd0, exp});
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0;
    endtask

    logic [15:0] bp_in  [12];
    logic [15:0] bp_exp [6];
    logic [15:0] got [$];
    logic [31:0] obs;

    initial begin
        bp_in  = '{16'h0100, 16'h0300, 16'hFF00, 16'hFE00, 16'h0001, 16'h0002,
                   16'h1234, 16'h0000, 16'h4000, 16'hE000, 16'h8000, 16'h7FFF};
        bp_exp = '{16'h0200, 16'hFE80, 16'h0001, 16'h091A, 16'h1000, 16'hFFFF};

        reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; corrupt_en = 1'b0;
        repeat (3) tick;
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_add_en", {31'd0, add_en}, 32'd0);
        check("rst_add_a", {16'd0, add_a}, 32'd0);
        check("rst_add_b", {16'd0, add_b}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {16'd0, m_data}, 32'd0);
        check("rst_err", {31'd0, err_mismatch}, 32'd0);
        reset = 1'b0;
        tick;
        check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

        // Basic pair 1.0 + 2.0 = 3.0 (Q9.7 0x0180)
        send(16'h0100);
        send(16'h0200);
        check("basic_add_en_hi", {31'd0, add_en}, 32'd1);
        check("basic_s_ready_issue", {31'd0, s_ready}, 32'd0);
        check("basic_add_a", {16'd0, add_a}, 32'h0100);
        check("basic_add_b", {16'd0, add_b}, 32'h0200);
        tick;
        check("basic_add_en_pulse", {31'd0, add_en}, 32'd0);
        check("basic_m_valid_early", {31'd0, m_valid}, 32'd0);
        for (int k = 1; k < L; k++) begin
            tick;
            check("basic_m_valid_early", {31'd0, m_valid}, 32'd0);
            check("basic_add_en_wait", {31'd0, add_en}, 32'd0);
        end
        // Write edge is B-edge+L+1; m_valid is high for the (L+2)th cycle after the B edge.
        tick;
        check("basic_m_valid", {31'd0, m_valid}, 32'd1);
        check("basic_m_data", {16'd0, m_data}, 32'h0180);
        check("basic_s_ready_get_a", {31'd0, s_ready}, 32'd1);
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0;
        check("basic_popped", {31'd0, m_valid}, 32'd0);

        // Extremes
        send(16'h7FFF); send(16'h7FFF); get_result("max_pos", 16'h7FFF);
        send(16'h8000); send(16'h8000); get_result("max_neg", 16'h8000);
        send(16'hFFFF); send(16'h0000); get_result("minus_lsb", 16'hFFFF);
        check("ext_err", {31'd0, err_mismatch}, 32'd0);

        // Backpressure: 4 results fill the FIFO, 5th pair stalls in ISSUE
        for (int i = 0; i < 10; i++) send(bp_in[i]);
        for (int k = 0; k < 3; k++) begin
            tick;
            check("bp_stall_add_en", {31'd0, add_en}, 32'd0);
            check("bp_stall_s_ready", {31'd0, s_ready}, 32'd0);
            check("bp_head", {16'd0, m_data}, {16'd0, bp_exp[0]});
        end
        m_ready = 1'b1;
        fork
            begin
                send(bp_in[10]);
                send(bp_in[11]);
            end
            begin
                int n;
                n = 0;
                while (got.size() < 6 && n < 300) begin
                    if (m_valid) got.push_back(m_data);
                    tick;
                    n++;
                end
            end
        join
        check("bp_count", got.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            obs = (i < got.size()) ? {16'd0, got[i]} : 32'hFFFF_FFFF;
            check("bp_order", obs, {16'd0, bp_exp[i]});
        end
        repeat (10) tick;
        check("bp_no_dup", {31'd0, m_valid}, 32'd0);
        m_ready = 1'b0;

        // Reset during WAIT discards the in-flight sum
        send(16'h0100);
        send(16'h0200);
        tick;
        reset = 1'b1;
        #1;
        check("midrst_s_ready", {31'd0, s_ready}, 32'd0);
        repeat (2) tick;
        reset = 1'b0;
        tick;
        check("midrst_s_ready_rel", {31'd0, s_ready}, 32'd1);
        check("midrst_m_valid", {31'd0, m_valid}, 32'd0);
        check("midrst_add_a", {16'd0, add_a}, 32'd0);
        repeat (5) tick;
        check("midrst_late_sum", {31'd0, m_valid}, 32'd0);
        send(16'h0080); send(16'h0080); get_result("midrst_next", 16'h0080);
        repeat (8) tick;
        check("midrst_only_one", {31'd0, m_valid}, 32'd0);

`ifdef PAIR_SUM_CHECK_EN
        corrupt_en = 1'b1;
        send(16'h0100);
        send(16'h0100);
        check("chk_err_before", {31'd0, err_mismatch}, 32'd0);
        begin
            int n;
            n = 0;
            while (!m_valid && n < 100) begin
                tick;
                n++;
            end
        end
        check("chk_err_set", {31'd0, err_mismatch}, 32'd1);
        check("chk_bad_data", {16'd0, m_data}, 32'h0000);
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0;
        corrupt_en = 1'b0;
        send(16'h0200); send(16'h0200); get_result("chk_good", 16'h0200);
        check("chk_err_sticky", {31'd0, err_mismatch}, 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tick;
        check("chk_err_cleared", {31'd0, err_mismatch}, 32'd0);
`else
        send(16'h0100); send(16'h0100); get_result("nochk_pair", 16'h0100);
        check("nochk_err", {31'd0, err_mismatch}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
